color_sequencer: RTL and testbench



---
 rtl/color_sequencer_if.sv | 19 +
 rtl/color_sequencer.sv | 133 +++++++++++++
 tb/tb_color_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/color_sequencer_if.sv
// Button/frame inputs and color-select outputs of the color sequencer.
interface color_sequencer_if;
  logic       btnC;
  logic       auto_en;
  logic       frame_start;
  logic [1:0] color_sel;
  logic       pending;
  logic       press_evt;

  modport master (
    output btnC, auto_en, frame_start,
    input  color_sel, pending, press_evt
  );

  modport slave (
    input  btnC, auto_en, frame_start,
    output color_sel, pending, press_evt
  );
endinterface

// File: rtl/color_sequencer.sv
// Debounced button / auto-cycle color selector; color changes only at frame_start
// so the generator never switches mid-frame.
module color_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned AUTO_FRAMES     = 60
) (
  input logic               clk,
  input logic               rst,
  color_sequencer_if.slave  sel_if
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FR_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  // Transition fires on the sample that brings the counter to DEBOUNCE_CYCLES-1.
  localparam logic [DB_W-1:0] DB_DONE_AT = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [FR_W-1:0] FR_LAST    = FR_W'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } db_state_e;

  logic            btn_meta_q, btn_s_q;
  logic            auto_meta_q, auto_s_q;
  db_state_e       state_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            press_evt_q;

  logic [1:0]      color_sel_q, color_sel_d;
  logic            pending_q, pending_d;
  logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            advance;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_q  <= 1'b0;
      btn_s_q     <= 1'b0;
      auto_meta_q <= 1'b0;
      auto_s_q    <= 1'b0;
    end else begin
      btn_meta_q  <= sel_if.btnC;
      btn_s_q     <= btn_meta_q;
      auto_meta_q <= sel_if.auto_en;
      auto_s_q    <= auto_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RELEASED;
      db_cnt_q    <= '0;
      press_evt_q <= 1'b0;
    end else begin
      press_evt_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (btn_s_q) begin
            db_cnt_q <= '0;
            state_q  <= PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (!btn_s_q) begin
            state_q <= RELEASED;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
            if (db_cnt_q == DB_DONE_AT) begin
              state_q     <= PRESSED;
              press_evt_q <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!btn_s_q) begin
            db_cnt_q <= '0;
            state_q  <= RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (btn_s_q) begin
            state_q <= PRESSED;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
            if (db_cnt_q == DB_DONE_AT) begin
              state_q <= RELEASED;
            end
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  always_comb begin
    advance     = sel_if.frame_start &&
                  (pending_q || (auto_s_q && (frame_cnt_q == FR_LAST)));
    color_sel_d = color_sel_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    if (advance) begin
      color_sel_d = color_sel_q + 2'd1;
      pending_d   = 1'b0;
    end
    // A press arriving with the frame pulse survives that frame's clear; one already pending is dropped.
    if (press_evt_q && !pending_q) begin
      pending_d = 1'b1;
    end
    if (!auto_s_q || advance) begin
      frame_cnt_d = '0;
    end else if (sel_if.frame_start) begin
      frame_cnt_d = frame_cnt_q + FR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_sel_q <= '0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      color_sel_q <= color_sel_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sel_if.color_sel = color_sel_q;
  assign sel_if.pending   = pending_q;
  assign sel_if.press_evt = press_evt_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer with DEBOUNCE_CYCLES=4, AUTO_FRAMES=3.
module tb_color_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  color_sequencer_if bus ();

  color_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_FRAMES     (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       fs;
    logic [1:0] sel;
    logic       pend;
    logic       evt;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic btn, input logic fs, input logic [1:0] sel,
                         input logic pend, input logic evt);
    vec_t v;
    v.btn = btn; v.fs = fs; v.sel = sel; v.pend = pend; v.evt = evt;
    vecs.push_back(v);
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic press_and_release(output int n_evt);
    n_evt = 0;
    bus.btnC = 1'b1;
    repeat (12) begin
      tick();
      if (bus.press_evt) n_evt++;
    end
    bus.btnC = 1'b0;
    repeat (10) begin
      tick();
      if (bus.press_evt) n_evt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check("reset sel", int'(bus.color_sel), 0);
  endtask

  initial begin
    int n1, n2, evt_seen;
    int exp_auto[7];
    int exp_restart[4];
    logic found;

    bus.btnC = 1'b0;
    bus.auto_en = 1'b0;
    bus.frame_start = 1'b0;

    // Clean press held 20 cycles, then a frame_start after release begins.
    for (int i = 0; i < 20; i++) add_vec(1'b1, 1'b0, 2'd0, (i >= 6), (i == 5));
    add_vec(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add_vec(1'b0, 1'b0, 2'd1, 1'b0, 1'b0);

    #1 rst = 1'b0;
    #1;
    check("rst sel", int'(bus.color_sel), 0);
    check("rst pending", int'(bus.pending), 0);
    check("rst press_evt", int'(bus.press_evt), 0);
    tick();
    tick();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.btnC = vecs[i].btn;
      bus.frame_start = vecs[i].fs;
      tick();
      check($sformatf("vec%0d sel", i), int'(bus.color_sel), int'(vecs[i].sel));
      check($sformatf("vec%0d pending", i), int'(bus.pending), int'(vecs[i].pend));
      check($sformatf("vec%0d press_evt", i), int'(bus.press_evt), int'(vecs[i].evt));
    end
    bus.frame_start = 1'b0;
    bus.btnC = 1'b0;

    // Bounce: 2-cycle toggles never satisfy the debounce window.
    for (int c = 0; c < 30; c++) begin
      bus.btnC = ((c / 2) % 2 == 0);
      tick();
      check($sformatf("bounce%0d press_evt", c), int'(bus.press_evt), 0);
    end
    bus.btnC = 1'b0;
    repeat (10) tick();
    check("bounce pending", int'(bus.pending), 0);
    check("bounce sel", int'(bus.color_sel), 1);

    // Four press/frame pairs from WHITE wrap back to WHITE.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      press_and_release(n1);
      check($sformatf("wrap%0d evt count", k), n1, 1);
      check($sformatf("wrap%0d pending", k), int'(bus.pending), 1);
      frame();
      check($sformatf("wrap%0d sel", k), int'(bus.color_sel), (k + 1) % 4);
      check($sformatf("wrap%0d pending clr", k), int'(bus.pending), 0);
      tick();
    end

    // press_evt coinciding with frame_start is deferred one frame.
    found = 1'b0;
    bus.btnC = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (bus.press_evt) found = 1'b1;
    end
    check("coinc evt seen", int'(found), 1);
    frame();
    check("coinc sel held", int'(bus.color_sel), 0);
    check("coinc pending", int'(bus.pending), 1);
    bus.btnC = 1'b0;
    repeat (10) tick();
    frame();
    check("coinc sel next", int'(bus.color_sel), 1);

    // Two presses before one frame give one advance, nothing queued.
    press_and_release(n1);
    press_and_release(n2);
    check("double evt1", n1, 1);
    check("double evt2", n2, 1);
    frame();
    check("double sel", int'(bus.color_sel), 2);
    check("double pending", int'(bus.pending), 0);
    tick();
    frame();
    check("double no queue", int'(bus.color_sel), 2);

    // Auto mode: advance on every 3rd frame.
    do_reset();
    bus.auto_en = 1'b1;
    repeat (4) tick();
    exp_auto = '{0, 0, 1, 1, 1, 2, 2};
    for (int p = 0; p < 7; p++) begin
      frame();
      check($sformatf("auto p%0d sel", p + 1), int'(bus.color_sel), exp_auto[p]);
      tick();
      tick();
    end
    press_and_release(n1);
    check("auto press pending", int'(bus.pending), 1);
    exp_restart = '{3, 3, 3, 0};
    for (int p = 0; p < 4; p++) begin
      frame();
      check($sformatf("restart p%0d sel", p + 8), int'(bus.color_sel), exp_restart[p]);
      tick();
    end
    frame();
    tick();
    frame();
    tick();
    check("coexp pre sel", int'(bus.color_sel), 0);
    press_and_release(n1);
    frame();
    check("coexp sel", int'(bus.color_sel), 1);
    check("coexp pending", int'(bus.pending), 0);
    tick();
    frame();
    check("coexp single", int'(bus.color_sel), 1);
    bus.auto_en = 1'b0;
    repeat (4) tick();

    // Asynchronous reset with pending set and a debounce in progress.
    press_and_release(n1);
    check("rstmid pending pre", int'(bus.pending), 1);
    bus.btnC = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check("rstmid sel", int'(bus.color_sel), 0);
    check("rstmid pending", int'(bus.pending), 0);
    check("rstmid press_evt", int'(bus.press_evt), 0);
    bus.btnC = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    evt_seen = 0;
    repeat (10) begin
      tick();
      if (bus.press_evt) evt_seen++;
    end
    check("rstmid no evt", evt_seen, 0);
    frame();
    check("rstmid no advance", int'(bus.color_sel), 0);
    check("rstmid pending post", int'(bus.pending), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
